// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// one read in flight at a time, with a starvation guard for the fetch port.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_if_o,
    output logic              stall_mem_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e     state_q;
    logic       owner_if_q;
    logic [3:0] lat_q;
    logic [3:0] starve_q;

    logic idle;
    logic if_win;
    logic dm_win;
    logic rd_done;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
    endfunction

    // Every output is qualified by rst_i so the block is silent while held in reset.
    always_comb begin
        idle    = rst_i & (state_q == IDLE);
        if_win  = idle & if_req_i & (~dm_req_i | (starve_q == STARVE_LIM));
        dm_win  = idle & dm_req_i & ~if_win;
        rd_done = rst_i & (state_q == BUSY) & (lat_q == 4'd1);
    end

    assign if_gnt_o    = if_win;
    assign dm_gnt_o    = dm_win;
    assign if_rvalid_o = rd_done & owner_if_q;
    assign dm_rvalid_o = rd_done & ~owner_if_q;
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;

    assign mem_req_o   = if_win | dm_win;
    assign mem_we_o    = dm_win & dm_we_i;
    assign mem_addr_o  = if_win ? if_addr_i : (dm_win ? dm_addr_i : '0);
    assign mem_wdata_o = dm_win ? dm_wdata_i : '0;

    assign stall_if_o  = rst_i & if_req_i & ~if_rvalid_o;
    assign stall_mem_o = rst_i & dm_req_i & ~dm_rvalid_o & ~(dm_win & dm_we_i);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            owner_if_q <= 1'b1;
            lat_q      <= 4'd0;
            starve_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_win) begin
                        state_q    <= BUSY;
                        owner_if_q <= 1'b1;
                        lat_q      <= LAT_INIT;
                        starve_q   <= 4'd0;
                    end else if (dm_win) begin
                        // Writes retire at the issuing edge, so only reads occupy the port.
                        if (!dm_we_i) begin
                            state_q    <= BUSY;
                            owner_if_q <= 1'b0;
                            lat_q      <= LAT_INIT;
                        end
                        if (if_req_i) begin
                            starve_q <= sat_inc(starve_q);
                        end
                    end
                end
                BUSY: begin
                    lat_q <= lat_q - 4'd1;
                    if (lat_q == 4'd1) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=2 and MEM_LAT=1) share stimulus
// and are compared every cycle against a timestamp-based reference model.
module tb_mem_port_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [63:0] mem_rdata;

    logic        if_gnt[2], if_rvalid[2], dm_gnt[2], dm_rvalid[2];
    logic        mem_req[2], mem_we[2], stall_if[2], stall_mem[2];
    logic [63:0] if_rdata[2], dm_rdata[2], mem_addr[2], mem_wdata[2];

    int nerr = 0;
    int nchk = 0;
    int cyc  = 0;

    // Reference state: cycle in which the outstanding read returns (-1 = none).
    int m_rv[2];
    int m_starve[2];
    bit m_own_if[2];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2), .STARVE_MAX(SMAX)) u_lat2 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt[0]),
        .if_rvalid_o(if_rvalid[0]), .if_rdata_o(if_rdata[0]),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt[0]), .dm_rvalid_o(dm_rvalid[0]), .dm_rdata_o(dm_rdata[0]),
        .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
        .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata),
        .stall_if_o(stall_if[0]), .stall_mem_o(stall_mem[0])
    );

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_lat1 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt[1]),
        .if_rvalid_o(if_rvalid[1]), .if_rdata_o(if_rdata[1]),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt[1]), .dm_rvalid_o(dm_rvalid[1]), .dm_rdata_o(dm_rdata[1]),
        .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
        .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata),
        .stall_if_o(stall_if[1]), .stall_mem_o(stall_mem[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic chk1(input string nm, input int k, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d] cycle %0d: got %b expected %b", nm, k, cyc, act, exp);
        end
    endtask

    task automatic chk64(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d] cycle %0d: got %h expected %h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int k);
        logic        e_ig, e_dg, e_ir, e_dr, e_mreq, e_we, e_sif, e_smem;
        logic [63:0] e_ird, e_drd, e_addr, e_wd;
        bit          idle, rvnow;
        e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0; e_mreq = 0; e_we = 0; e_sif = 0; e_smem = 0;
        e_ird = '0; e_drd = '0; e_addr = '0; e_wd = '0;
        if (rst) begin
            idle  = (m_rv[k] < cyc);
            rvnow = (m_rv[k] == cyc);
            if (idle && if_req && dm_req) begin
                if (m_starve[k] == SMAX) e_ig = 1; else e_dg = 1;
            end else if (idle && if_req) begin
                e_ig = 1;
            end else if (idle && dm_req) begin
                e_dg = 1;
            end
            if (rvnow) begin
                if (m_own_if[k]) begin e_ir = 1; e_ird = mem_rdata; end
                else begin e_dr = 1; e_drd = mem_rdata; end
            end
            e_mreq = e_ig | e_dg;
            e_we   = e_dg & dm_we;
            e_addr = e_ig ? if_addr : (e_dg ? dm_addr : 64'd0);
            e_wd   = e_dg ? dm_wdata : 64'd0;
            e_sif  = if_req & ~e_ir;
            e_smem = dm_req & ~e_dr & ~(e_dg & dm_we);
        end
        chk1("if_gnt", k, if_gnt[k], e_ig);
        chk1("dm_gnt", k, dm_gnt[k], e_dg);
        chk1("if_rvalid", k, if_rvalid[k], e_ir);
        chk1("dm_rvalid", k, dm_rvalid[k], e_dr);
        chk64("if_rdata", k, if_rdata[k], e_ird);
        chk64("dm_rdata", k, dm_rdata[k], e_drd);
        chk1("mem_req", k, mem_req[k], e_mreq);
        chk1("mem_we", k, mem_we[k], e_we);
        chk64("mem_addr", k, mem_addr[k], e_addr);
        chk64("mem_wdata", k, mem_wdata[k], e_wd);
        chk1("stall_if", k, stall_if[k], e_sif);
        chk1("stall_mem", k, stall_mem[k], e_smem);
        if (!rst) begin
            m_rv[k] = -1;
            m_starve[k] = 0;
            m_own_if[k] = 1;
        end else if (e_ig) begin
            m_rv[k] = cyc + lat_of(k);
            m_own_if[k] = 1;
            m_starve[k] = 0;
        end else if (e_dg) begin
            if (!dm_we) begin
                m_rv[k] = cyc + lat_of(k);
                m_own_if[k] = 0;
            end
            if (if_req && m_starve[k] < SMAX) m_starve[k]++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step(0);
        model_step(1);
        cyc++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        if_req = 0; dm_req = 0;
        for (int i = 0; i < n; i++) begin cycle(); adv(); end
    endtask

    initial begin
        bit done_dm;
        for (int k = 0; k < 2; k++) begin m_rv[k] = -1; m_starve[k] = 0; m_own_if[k] = 1; end
        rst = 0; if_req = 1; dm_req = 1; dm_we = 0;
        if_addr = 64'h10; dm_addr = 64'h20; dm_wdata = 64'h5; mem_rdata = 64'h77;

        // Reset holds all outputs low even with requests present
        cycle();
        chk1("rst_mem_req", 0, mem_req[0], 1'b0);
        chk1("rst_stall_if", 0, stall_if[0], 1'b0);
        chk1("rst_dm_gnt", 0, dm_gnt[0], 1'b0);
        adv(); cycle(); adv();
        rst = 1;
        quiet(1);

        // Lone fetch
        if_req = 1; if_addr = 64'h40;
        cycle();
        chk1("t1_if_gnt", 0, if_gnt[0], 1'b1);
        chk1("t1_mem_req", 0, mem_req[0], 1'b1);
        chk64("t1_mem_addr", 0, mem_addr[0], 64'h40);
        chk1("t1_stall_T", 0, stall_if[0], 1'b1);
        adv(); cycle();
        chk1("t1_stall_T1", 0, stall_if[0], 1'b1);
        chk1("t1_no_regrant", 0, if_gnt[0], 1'b0);
        adv(); mem_rdata = 64'hCAFE; cycle();
        chk1("t1_if_rvalid", 0, if_rvalid[0], 1'b1);
        chk64("t1_if_rdata", 0, if_rdata[0], 64'hCAFE);
        chk1("t1_stall_T2", 0, stall_if[0], 1'b0);
        adv();
        quiet(3);

        // Read contention
        if_req = 1; if_addr = 64'h44; dm_req = 1; dm_we = 0; dm_addr = 64'h200;
        cycle();
        chk1("t2_dm_gnt", 0, dm_gnt[0], 1'b1);
        chk1("t2_if_lose", 0, if_gnt[0], 1'b0);
        adv(); cycle(); adv();
        mem_rdata = 64'hBEEF; cycle();
        chk1("t2_dm_rvalid", 0, dm_rvalid[0], 1'b1);
        chk64("t2_dm_rdata", 0, dm_rdata[0], 64'hBEEF);
        adv(); dm_req = 0; cycle();
        chk1("t2_if_gnt_T3", 0, if_gnt[0], 1'b1);
        adv(); cycle(); adv(); cycle();
        chk1("t2_if_rvalid_T5", 0, if_rvalid[0], 1'b1);
        adv();
        quiet(3);

        // Write then read
        dm_req = 1; dm_we = 1; dm_addr = 64'h100; dm_wdata = 64'hDEAD; if_req = 1; if_addr = 64'h48;
        cycle();
        chk1("t3_dm_gnt", 0, dm_gnt[0], 1'b1);
        chk1("t3_mem_we", 0, mem_we[0], 1'b1);
        chk64("t3_mem_addr", 0, mem_addr[0], 64'h100);
        chk64("t3_mem_wdata", 0, mem_wdata[0], 64'hDEAD);
        chk1("t3_stall_mem", 0, stall_mem[0], 1'b0);
        adv(); dm_req = 0; cycle();
        chk1("t3_if_gnt_T1", 0, if_gnt[0], 1'b1);
        adv(); cycle(); adv(); cycle(); adv();
        quiet(3);

        // Starvation: four DM wins, then IF forces through
        if_req = 1; if_addr = 64'h4C; dm_req = 1; dm_we = 1;
        for (int i = 0; i < 4; i++) begin
            dm_addr = 64'h300 + 64'(8 * i);
            cycle();
            chk1("t4_dm_wins", 0, dm_gnt[0], 1'b1);
            chk1("t4_if_loses", 0, if_gnt[0], 1'b0);
            adv();
        end
        cycle();
        chk1("t4_if_forced", 0, if_gnt[0], 1'b1);
        chk1("t4_dm_held", 0, dm_gnt[0], 1'b0);
        chk1("t4_stall_mem", 0, stall_mem[0], 1'b1);
        adv(); cycle(); adv(); cycle();
        chk1("t4_if_rvalid", 0, if_rvalid[0], 1'b1);
        adv(); cycle();
        chk1("t4_starve_cleared", 0, dm_gnt[0], 1'b1);
        adv();
        quiet(3);

        // Reset in the middle of a read
        if_req = 1; if_addr = 64'h50;
        cycle();
        chk1("t5_if_gnt", 0, if_gnt[0], 1'b1);
        adv(); rst = 0; cycle();
        chk1("t5_rst_gnt", 0, if_gnt[0], 1'b0);
        chk1("t5_rst_mreq", 0, mem_req[0], 1'b0);
        chk1("t5_rst_stall", 0, stall_if[0], 1'b0);
        adv(); rst = 1; cycle();
        chk1("t5_no_rvalid", 0, if_rvalid[0], 1'b0);
        chk1("t5_fresh_gnt", 0, if_gnt[0], 1'b1);
        adv();
        quiet(3);

        // MEM_LAT=1 back-to-back fetches
        rst = 0; cycle(); adv(); rst = 1;
        if_req = 1; if_addr = 64'h60;
        cycle(); chk1("t6_gnt_T", 1, if_gnt[1], 1'b1); adv();
        cycle(); chk1("t6_rv_T1", 1, if_rvalid[1], 1'b1); chk1("t6_nogr_T1", 1, if_gnt[1], 1'b0); adv();
        cycle(); chk1("t6_gnt_T2", 1, if_gnt[1], 1'b1); adv();
        cycle(); chk1("t6_rv_T3", 1, if_rvalid[1], 1'b1); adv();
        quiet(3);

        // Randomized traffic, loosely following the request protocol of the LAT=2 instance
        for (int n = 0; n < 3000; n++) begin
            cycle();
            done_dm = dm_rvalid[0] | (dm_gnt[0] & dm_we);
            adv();
            if (if_req && (if_rvalid[0] || $urandom_range(0, 19) == 0)) if_req = 0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = {$urandom, $urandom};
            end
            if (dm_req && (done_dm || $urandom_range(0, 19) == 0)) dm_req = 0;
            else if (!dm_req && $urandom_range(0, 1) == 0) begin
                dm_req = 1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = {$urandom, $urandom}; dm_wdata = {$urandom, $urandom};
            end
            rst = ($urandom_range(0, 150) != 0);
            mem_rdata = {$urandom, $urandom};
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequenced arbiter sharing one single-port unified memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage RISC-V pipeline. It holds at most one transaction in flight and counts out a fixed memory read latency. It returns read data to the winning port and drives per-stage stall outputs that freeze the PC and pipeline registers. Data accesses normally win, and a starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 64, address width of both ports and memory
- DATA_W, 64, data width of both ports and memory
- MEM_LAT, 2, cycles from read issue to valid mem_rdata_i; legal range 1..15
- STARVE_MAX, 4, consecutive lost arbitrations after which IF wins; legal range 1..15
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-low reset
- if_req_i  input  1  fetch read request, held until if_rvalid_o
- if_addr_i  input  ADDR_W  fetch address, stable while if_req_i
- if_gnt_o  output  1  fetch issued this cycle
- if_rvalid_o  output  1  fetch data valid this cycle
- if_rdata_o  output  DATA_W  fetch data
- dm_req_i  input  1  data request, held until dm_rvalid_o (read) or dm_gnt_o (write)
- dm_we_i  input  1  1 means write, 0 means read
- dm_addr_i  input  ADDR_W  data address
- dm_wdata_i  input  DATA_W  write data
- dm_gnt_o  output  1  data access issued this cycle
- dm_rvalid_o  output  1  data read valid this cycle
- dm_rdata_o  output  DATA_W  data read result
- mem_req_o  output  1  memory access strobe
- mem_we_o  output  1  memory write enable
- mem_addr_o  output  ADDR_W  memory address
- mem_wdata_o  output  DATA_W  memory write data
- mem_rdata_i  input  DATA_W  memory read data, valid exactly MEM_LAT cycles after a read strobe
- stall_if_o  output  1  freeze PC and IF/ID
- stall_mem_o  output  1  freeze the whole pipeline up to and including EX/MEM

## Operation
- FSM states:
  - IDLE: may issue.
  - BUSY: a read is outstanding. Registers: owner (IF or DM), latency counter lat_cnt, starve counter starve_cnt.
- Arbitration (IDLE only, combinational):
  - Only one requester: that requester wins.
  - Both requesting: DM wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
- Issue:
  - Assert the winner's gnt and mem_req_o.
  - Drive mem_addr_o, mem_we_o and mem_wdata_o from the winner. IF always issues we=0, wdata=0.
  - With no grant, mem_req_o=0 and other mem outputs are 0.
- Read issue: IDLE→BUSY, lat_cnt ← MEM_LAT, owner latched.
- Write issue: completes at the issuing edge. State stays IDLE, so a new issue is allowed in the next cycle.
- BUSY:
  - lat_cnt decrements each cycle.
  - In the cycle lat_cnt == 1, the owner's rvalid is 1 and its rdata = mem_rdata_i (combinational pass-through). FSM → IDLE at that edge.
  - No issue is possible in BUSY.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each IDLE cycle where both ports request and DM wins.
  - Clears to 0 on if_gnt_o.
  - Otherwise holds.
- Non-owner rvalid is always 0. rdata outputs are 0 when their rvalid is 0.
- Stalls:
  - stall_if_o = if_req_i & ~if_rvalid_o.
  - stall_mem_o = dm_req_i & ~dm_rvalid_o & ~(dm_gnt_o & dm_we_i).
- Requester drops req while BUSY: the transaction still completes, and rvalid pulses to the owner regardless.

## Timing
- Read issued in cycle T: rvalid in cycle T+MEM_LAT; earliest next issue T+MEM_LAT+1.
- Read throughput is one per MEM_LAT+1 cycles. Write throughput is one per cycle.
- Grant and mem strobe are combinational from requests in the same cycle.
- Reset:
  - While rst_i==0: all outputs 0, regardless of inputs.
  - At the edge: state ← IDLE, lat_cnt ← 0, starve_cnt ← 0, owner ← IF.
- Reset in BUSY: the in-flight read is abandoned and no rvalid is produced. The first cycle after reset release is IDLE and may issue.
- Simultaneous request arrival in IDLE: resolved in the same cycle. A loser's request is re-arbitrated at the next IDLE cycle.

## Test plan
- Lone fetch: MEM_LAT=2, if_req_i=1 with addr 0x40 at T. Required: if_gnt_o and mem_req_o at T, mem_addr_o=0x40; if_rvalid_o at T+2 with mem_rdata_i value; stall_if_o high at T and T+1, low at T+2.
- Read contention: both request reads at T. Required: dm_gnt_o at T, dm_rvalid_o at T+2, if_gnt_o at T+3, if_rvalid_o at T+5.
- Write then read: dm write addr 0x100, data 0xDEAD at T, with IF also requesting. Required: dm_gnt_o and mem_we_o=1 at T, stall_mem_o=0 at T; if_gnt_o at T+1.
- Starvation: STARVE_MAX=4, IF held requesting while DM issues back-to-back writes. Required: DM wins cycles T..T+3; IF wins at T+4 even with dm_req_i=1; starve_cnt then reads 0.
- Reset mid-read: read issued at T, rst_i=0 at T+1 only. Required: all outputs 0 at T+1; no rvalid at T+2; fresh request granted at T+2.
- MEM_LAT=1: back-to-back IF reads. Required: grants at T and T+2, rvalids at T+1 and T+3.
